// File: rtl/panel_axi_pkg.sv
// panel_axi_pkg: response codes and word map shared by the panel AXI register file
package panel_axi_pkg;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam int REG_CTRL    = 0;
    localparam int REG_BRIGHT  = 1;
    localparam int REG_FRAME   = 2;
    localparam int REG_SCAN    = 3;
    localparam int REG_STATUS  = 4;
    localparam int NUM_RW_REGS = 4;
    function automatic logic is_rw(input logic [2:0] idx);
        return idx < 3'(NUM_RW_REGS);
    endfunction
endpackage

// File: rtl/panel_axi_wr_buf.sv
// panel_axi_wr_buf: one-entry valid/ready holding buffer for an AXI write channel
module panel_axi_wr_buf #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             clear,
    output logic             full,
    output logic [WIDTH-1:0] data
);
    assign in_ready = !full;
    // capture one beat while empty, release it when the commit consumes it
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
            data <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (in_valid && !full) begin
            full <= 1'b1;
            data <= in_data;
        end
    end
endmodule

// File: rtl/panel_axi_regs.sv
// panel_axi_regs: AXI4-Lite register file for the LED panel (PANEL_AXI_REGS_SLVERR_EN enables SLVERR on unmapped/RO writes)
module panel_axi_regs
    import panel_axi_pkg::*;
#(
    parameter int                   DATA_WIDTH = 32,
    parameter int                   ADDR_WIDTH = 5,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL = 32'h0
) (
    input  logic                                     ACLK,
    input  logic                                     ARESET,
    input  logic [ADDR_WIDTH-1:0]                    S_AXI_AWADDR,
    input  logic [2:0]                               S_AXI_AWPROT,
    input  logic                                     S_AXI_AWVALID,
    output logic                                     S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]                    S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]                  S_AXI_WSTRB,
    input  logic                                     S_AXI_WVALID,
    output logic                                     S_AXI_WREADY,
    output logic [1:0]                               S_AXI_BRESP,
    output logic                                     S_AXI_BVALID,
    input  logic                                     S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]                    S_AXI_ARADDR,
    input  logic [2:0]                               S_AXI_ARPROT,
    input  logic                                     S_AXI_ARVALID,
    output logic                                     S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]                    S_AXI_RDATA,
    output logic [1:0]                               S_AXI_RRESP,
    output logic                                     S_AXI_RVALID,
    input  logic                                     S_AXI_RREADY,
    output logic [NUM_RW_REGS-1:0][DATA_WIDTH-1:0]   reg_out,
    output logic [NUM_RW_REGS-1:0]                   reg_wr_pulse,
    input  logic [DATA_WIDTH-1:0]                    status_in
);
    localparam int IW = ADDR_WIDTH - 2;
    localparam int SW = DATA_WIDTH / 8;
    logic                       aw_full, w_full, commit;
    logic [IW-1:0]              aw_idx, ar_idx;
    logic [SW+DATA_WIDTH-1:0]   w_word;
    logic [SW-1:0]              w_strb;
    logic [DATA_WIDTH-1:0]      w_data, rd_mux;
    logic [1:0]                 wr_resp, rd_resp;
    logic                       unused;

    assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
    assign w_strb = w_word[SW+DATA_WIDTH-1:DATA_WIDTH];
    assign w_data = w_word[DATA_WIDTH-1:0];
    assign ar_idx = S_AXI_ARADDR[ADDR_WIDTH-1:2];
    assign S_AXI_ARREADY = !S_AXI_RVALID || S_AXI_RREADY;

    panel_axi_wr_buf #(.WIDTH(IW)) u_aw_buf (
        .clk(ACLK), .rst(ARESET), .in_data(S_AXI_AWADDR[ADDR_WIDTH-1:2]),
        .in_valid(S_AXI_AWVALID), .in_ready(S_AXI_AWREADY),
        .clear(commit), .full(aw_full), .data(aw_idx)
    );

    panel_axi_wr_buf #(.WIDTH(SW + DATA_WIDTH)) u_w_buf (
        .clk(ACLK), .rst(ARESET), .in_data({S_AXI_WSTRB, S_AXI_WDATA}),
        .in_valid(S_AXI_WVALID), .in_ready(S_AXI_WREADY),
        .clear(commit), .full(w_full), .data(w_word)
    );

    // commit when both halves are held and the B slot is free; read mux and responses
    always_comb begin
        commit = aw_full && w_full && (!S_AXI_BVALID || S_AXI_BREADY);
        rd_mux = is_rw(ar_idx) ? reg_out[ar_idx[1:0]] :
                 (ar_idx == IW'(REG_STATUS)) ? status_in : '0;
`ifdef PANEL_AXI_REGS_SLVERR_EN
        wr_resp = is_rw(aw_idx) ? OKAY : SLVERR;
        rd_resp = (ar_idx <= IW'(REG_STATUS)) ? OKAY : SLVERR;
`else
        wr_resp = OKAY;
        rd_resp = OKAY;
`endif
    end

    // byte-lane update of the RW registers and the per-register commit pulse
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            reg_out      <= {NUM_RW_REGS{RESET_VAL}};
            reg_wr_pulse <= '0;
        end else begin
            for (int i = 0; i < NUM_RW_REGS; i++) begin
                reg_wr_pulse[i] <= commit && (aw_idx == IW'(i));
                for (int b = 0; b < SW; b++)
                    if (commit && (aw_idx == IW'(i)) && w_strb[b])
                        reg_out[i][8*b +: 8] <= w_data[8*b +: 8];
            end
        end
    end

    // write response: raised on commit, held until BREADY
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP  <= OKAY;
        end else if (commit) begin
            S_AXI_BVALID <= 1'b1;
            S_AXI_BRESP  <= wr_resp;
        end else if (S_AXI_BREADY) begin
            S_AXI_BVALID <= 1'b0;
        end
    end

    // read data: registered on AR handshake from pre-commit register contents
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            S_AXI_RVALID <= 1'b0;
            S_AXI_RDATA  <= '0;
            S_AXI_RRESP  <= OKAY;
        end else if (S_AXI_ARVALID && S_AXI_ARREADY) begin
            S_AXI_RVALID <= 1'b1;
            S_AXI_RDATA  <= rd_mux;
            S_AXI_RRESP  <= rd_resp;
        end else if (S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
        end
    end
endmodule

// File: doc/panel_axi_regs.md
# panel_axi_regs

AXI4-Lite slave register file for the LED panel driver: the responder that answers the AXI4-Lite master's single-beat writes and reads on the S00_AXI port. It holds four 32-bit read/write control words that drive the panel logic and one read-only status word. It sits between the PS interconnect and the panel timing/scan logic.

## Interface
- DATA_WIDTH, 32, AXI data width; fixed at 32, other values unsupported
- ADDR_WIDTH, 5, byte address bits decoded; 8 word slots at offsets 0x00–0x1C
- RESET_VAL, 32'h0, reset value of all RW registers

Ports:
- ACLK  in  1  clock
- ARESET  in  1  synchronous, active-high reset
- S_AXI_AWADDR  in  ADDR_WIDTH  write address; bits [1:0] ignored
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  byte lane enables
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake
- S_AXI_BRESP  out  2  write response
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake
- S_AXI_ARADDR  in  ADDR_WIDTH  read address; bits [1:0] ignored
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake
- S_AXI_RDATA  out  32  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake
- S_AXI_AWPROT, S_AXI_ARPROT  in  3  accepted and ignored
- reg_out  out  4×32  current values of RW registers 0–3
- reg_wr_pulse  out  4  one-cycle pulse per RW register on commit
- status_in  in  32  sampled on read of word 4

## Operation
- Map by word index: 0–3 are RW, 4 is RO status_in, 5–7 are unmapped.
- Write channel: independent one-entry AW and W holding buffers. AWREADY = AW buffer empty. WREADY = W buffer empty. AW and W may arrive in either order or in the same cycle.
- Commit: when both buffers are full and (!BVALID or BREADY), apply byte lanes per WSTRB to the target RW register, pulse reg_wr_pulse[idx], clear both buffers and set BVALID. Writes to word 4–7 change no state and produce no pulse.
- Read channel: ARREADY = !RVALID or RREADY. On AR handshake, RDATA is registered from the current register contents (read-before-write on same-edge commit) and RVALID is set. Unmapped reads return 0.
- BVALID/RVALID stay high until their ready. RDATA/BRESP are stable while valid.
- Reset: all RW registers = RESET_VAL; buffers empty; AWREADY=WREADY=ARREADY=1 during the first cycle after reset; BVALID=RVALID=0; RDATA=0; BRESP=RRESP=OKAY; reg_wr_pulse=0. Reset mid-transaction discards all pending transfers without a response.

## Timing
- Write: AW and W handshake in cycle N → commit at edge ending N+1 → BVALID and the updated reg_out are visible in N+2. reg_wr_pulse is high in N+2 only.
- Back-to-back writes: with BREADY held high, the next AW/W is accepted in N+2, giving a sustained rate of one write per 2 cycles.
- BREADY low: buffers stay full and AWREADY/WREADY stay low, so there is no second write until the B handshake.
- Read: AR handshake in cycle N → RVALID in N+1. With RREADY held high, one read per cycle is sustained.
- A simultaneous read and write commit to the same register returns the pre-write value.

## Configuration
- PANEL_AXI_REGS_SLVERR_EN defined: accesses to words 5–7 return SLVERR (2'b10) on BRESP/RRESP. Writes to word 4 return SLVERR.
- Not defined: all accesses respond OKAY. Unmapped writes are silently dropped and unmapped reads return 0.

## Structure
- Shared package panel_axi_pkg holds:
  - resp constants OKAY=2'b00, SLVERR=2'b10
  - word index constants REG_CTRL=0, REG_BRIGHT=1, REG_FRAME=2, REG_SCAN=3, REG_STATUS=4
  - NUM_RW_REGS=4
- One natural sub-module: panel_axi_wr_buf, the one-entry valid/ready holding buffer, instantiated once for AW and once for W.

## Test plan
- Reset, then write 0x0101FFFF, 0xABCD0001, 0xDEAD0011 and 0xBEEF0011 to 0x00/0x04/0x08/0x0C, reading back each → each read equals the written data, all responses OKAY, and reg_wr_pulse fires once per write.
- W presented 3 cycles before AW, then AW presented before W → both commit correctly, with BVALID 2 cycles after the later handshake.
- Write 0xFFFFFFFF to 0x04, then 0x00000000 with WSTRB=4'b0101 → readback 0xFF00FF00.
- Hold BREADY low for 5 cycles after a write → BVALID held and AWREADY/WREADY low throughout; next write accepted only after the B handshake.
- status_in=0x12345678, read 0x10 → 0x12345678. Write 0x10 then read 0x14 → no state change; SLVERR with PANEL_AXI_REGS_SLVERR_EN, OKAY/0 without it.
- Assert ARESET while BVALID is pending after writing 0xDEAD0011 → BVALID drops and register 2 reads 0x00000000.
